// File: rtl/fp_bcd_out.sv
// Converts one project floating-point word (s, 7-bit e, 15-bit m) into a signed
// 5-digit BCD integer part with status flags: bit-serial shift, then double dabble.
module fp_bcd_out (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_s,
    input  logic [6:0]  in_e,
    input  logic [14:0] in_m,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic        neg,
    output logic        zero_flag,
    output logic        inf_flag,
    output logic        overflow_flag,
    output logic        inexact_flag
);

    typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, BCD, DONE} state_t;

    localparam logic [6:0]  E_ZERO  = 7'h40;
    localparam logic [6:0]  E_INF   = 7'h3F;
    localparam logic [19:0] BCD_SAT = 20'h99999;
    localparam logic [16:0] ACC_MAX = 17'd99999;

    state_t      state;
    state_t      state_next;
    logic        s_q;
    logic [6:0]  e_q;
    logic [14:0] m_q;
    logic [16:0] acc;
    logic [16:0] acc_shift;
    logic [4:0]  cnt;
    logic        left_q;
    logic        inexact_q;
    logic [19:0] dd;
    logic [19:0] dd_adj;
    logic [19:0] dd_next;
    logic        is_special;

    // Cases resolved entirely in CLASSIFY: zero/inf codes, negative e, e >= 17.
    assign is_special = (e_q == E_ZERO) || (e_q == E_INF) || e_q[6] || (e_q > 7'd16);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        acc_shift  = left_q ? {acc[15:0], 1'b0} : {1'b0, acc[16:1]};
        dd_adj     = dd;
        for (int i = 0; i < 5; i++) begin
            if (dd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd[4*i +: 4] + 4'd3;
        end
        dd_next = {dd_adj[18:0], acc[16]};
        busy    = (state == CLASSIFY) || (state == SHIFT) || (state == BCD);
        done    = (state == DONE);
        case (state)
            IDLE:     if (start) state_next = CLASSIFY;
            CLASSIFY: begin
                if (is_special)          state_next = DONE;
                else if (e_q == 7'd14)   state_next = BCD;
                else                     state_next = SHIFT;
            end
            SHIFT: begin
                if (cnt == 5'd1) state_next = (acc_shift > ACC_MAX) ? DONE : BCD;
            end
            BCD:      if (cnt == 5'd16) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q           <= 1'b0;
            e_q           <= '0;
            m_q           <= '0;
            acc           <= '0;
            cnt           <= '0;
            left_q        <= 1'b0;
            inexact_q     <= 1'b0;
            dd            <= '0;
            bcd           <= '0;
            neg           <= 1'b0;
            zero_flag     <= 1'b0;
            inf_flag      <= 1'b0;
            overflow_flag <= 1'b0;
            inexact_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s_q           <= in_s;
                        e_q           <= in_e;
                        m_q           <= in_m;
                        neg           <= 1'b0;
                        zero_flag     <= 1'b0;
                        inf_flag      <= 1'b0;
                        overflow_flag <= 1'b0;
                        inexact_flag  <= 1'b0;
                    end
                end
                CLASSIFY: begin
                    if (e_q == E_ZERO) begin
                        zero_flag <= 1'b1;
                        bcd       <= '0;
                    end else if (e_q == E_INF) begin
                        inf_flag <= 1'b1;
                        bcd      <= BCD_SAT;
                        neg      <= ~s_q;
                    end else if (e_q[6]) begin
                        bcd          <= '0;
                        inexact_flag <= (m_q != 15'd0);
                    end else if (e_q > 7'd16) begin
                        overflow_flag <= 1'b1;
                        bcd           <= BCD_SAT;
                        neg           <= ~s_q;
                    end else begin
                        acc       <= {2'b00, m_q};
                        left_q    <= (e_q > 7'd14);
                        cnt       <= (e_q > 7'd14) ? (e_q[4:0] - 5'd14) : (5'd14 - e_q[4:0]);
                        inexact_q <= 1'b0;
                        dd        <= '0;
                    end
                end
                SHIFT: begin
                    acc <= acc_shift;
                    cnt <= cnt - 5'd1;
                    if (!left_q && acc[0]) inexact_q <= 1'b1;
                    // Only left shifts can push the integer part past 99999.
                    if (cnt == 5'd1 && acc_shift > ACC_MAX) begin
                        overflow_flag <= 1'b1;
                        bcd           <= BCD_SAT;
                        neg           <= ~s_q;
                    end
                end
                BCD: begin
                    dd  <= dd_next;
                    acc <= {acc[15:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd16) begin
                        bcd          <= dd_next;
                        neg          <= ~s_q & (dd_next != 20'd0);
                        inexact_flag <= inexact_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
